// File: rtl/or1200_alarm_ctrl.sv
// or1200_alarm_ctrl: filters checker failures, raises a held alarm IRQ with a latched syndrome, escalates to a sticky halt.
// Latency: FILT_CYC cycles from the first failing sample to alarm_irq; all outputs are registered.
// Backpressure: none; the alarm is held until alarm_ack. In lockout, ack and mask writes are ignored until reset.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   chk_ok[5:0]                       checker pass bits {supv, dmmu_fault, immu_fault, mmus, pipeline, sr}
//   alarm_ack                         one-cycle acknowledge from the exception handler
//   cfg_we / cfg_mask / cfg_supv      enable-mask write port (supervisor only, only while idle)
//   alarm_irq, syndrome, alarm_cnt    alarm request, accumulated failing checkers, acknowledged-alarm count
//   cpu_halt, cfg_err, mask           sticky halt, rejected-write pulse, current enable mask
//
// Build option: define OR1200_ALARM_LOCKOUT_EN to include the LOCKOUT state
// (cpu_halt after MAX_ALARMS acknowledged alarms). Without it, cpu_halt is tied to 0.

module or1200_alarm_ctrl #(
    parameter int unsigned FILT_CYC   = 2,
    parameter int unsigned MAX_ALARMS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] chk_ok,
    input  logic       alarm_ack,
    input  logic       cfg_we,
    input  logic [5:0] cfg_mask,
    input  logic       cfg_supv,
    output logic       alarm_irq,
    output logic [5:0] syndrome,
    output logic [3:0] alarm_cnt,
    output logic       cpu_halt,
    output logic       cfg_err,
    output logic [5:0] mask
);

    // Elaboration-time guard on the legal parameter ranges.
    if (FILT_CYC < 1 || FILT_CYC > 15) begin : g_bad_filt_cyc
        $error("or1200_alarm_ctrl: FILT_CYC must be in 1..15");
    end
    if (MAX_ALARMS < 1 || MAX_ALARMS > 15) begin : g_bad_max_alarms
        $error("or1200_alarm_ctrl: MAX_ALARMS must be in 1..15");
    end

    localparam logic [3:0] FILT_C = 4'(FILT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2
`ifdef OR1200_ALARM_LOCKOUT_EN
        , ST_LOCKOUT = 2'd3
`endif
    } state_t;

`ifdef OR1200_ALARM_LOCKOUT_EN
    localparam logic [3:0] MAX_C = 4'(MAX_ALARMS);
`endif

    state_t     state_q, state_d;
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic [5:0] syndrome_q, syndrome_d;
    logic [3:0] alarm_cnt_q, alarm_cnt_d;
    logic [5:0] mask_q, mask_d;
    logic       alarm_irq_q, alarm_irq_d;
    logic       cfg_err_q, cfg_err_d;
`ifdef OR1200_ALARM_LOCKOUT_EN
    logic       cpu_halt_q, cpu_halt_d;
`endif

    logic [5:0] fail;
    logic       any_fail;
    logic [3:0] cnt_inc;
    logic [3:0] filt_inc;
    logic       in_lockout;
    logic       going_lockout;

    always_comb begin
        // Fail vector uses the registered mask, so an accepted write takes
        // effect on the following cycle's sample.
        fail     = ~chk_ok & mask_q;
        any_fail = |fail;
        cnt_inc  = (alarm_cnt_q == 4'hf) ? 4'hf : alarm_cnt_q + 4'd1;
        filt_inc = filt_cnt_q + 4'd1;

`ifdef OR1200_ALARM_LOCKOUT_EN
        in_lockout = (state_q == ST_LOCKOUT);
`else
        in_lockout = 1'b0;
`endif

        state_d       = state_q;
        filt_cnt_d    = filt_cnt_q;
        syndrome_d    = syndrome_q;
        alarm_cnt_d   = alarm_cnt_q;
        mask_d        = mask_q;
        cfg_err_d     = 1'b0;
        going_lockout = 1'b0;

        // Mask writes: only a supervisor write while fully idle is accepted.
        // A locked-out controller ignores the strobe entirely (no error pulse).
        if (cfg_we && !in_lockout) begin
            if (cfg_supv && (state_q == ST_IDLE)) begin
                mask_d = cfg_mask;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (any_fail) begin
                    filt_cnt_d = 4'd1;
                    syndrome_d = fail;
                    state_d    = (FILT_C == 4'd1) ? ST_ALARM : ST_PENDING;
                end
            end

            ST_PENDING: begin
                // Different checkers may fail in different cycles; only
                // the run of non-empty fail vectors must be unbroken.
                if (any_fail) begin
                    filt_cnt_d = filt_inc;
                    syndrome_d = syndrome_q | fail;
                    if (filt_inc == FILT_C) begin
                        state_d = ST_ALARM;
                    end
                end else begin
                    filt_cnt_d = 4'd0;
                    syndrome_d = 6'd0;
                    state_d    = ST_IDLE;
                end
            end

            ST_ALARM: begin
                if (alarm_ack) begin
                    alarm_cnt_d = cnt_inc;
`ifdef OR1200_ALARM_LOCKOUT_EN
                    going_lockout = (cnt_inc >= MAX_C);
`endif
                    if (going_lockout) begin
`ifdef OR1200_ALARM_LOCKOUT_EN
                        state_d    = ST_LOCKOUT;
`endif
                        syndrome_d = syndrome_q | fail;
                    end else begin
                        // Ack beats a concurrent failure; a persisting
                        // failure is re-sampled from IDLE next cycle.
                        state_d    = ST_IDLE;
                        syndrome_d = 6'd0;
                        filt_cnt_d = 4'd0;
                    end
                end else begin
                    syndrome_d = syndrome_q | fail;
                end
            end

`ifdef OR1200_ALARM_LOCKOUT_EN
            ST_LOCKOUT: begin
                // Frozen until reset.
                state_d = ST_LOCKOUT;
            end
`endif

            default: begin
                state_d    = ST_IDLE;
                filt_cnt_d = 4'd0;
                syndrome_d = 6'd0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        alarm_irq_d = (state_d == ST_ALARM) || going_lockout || in_lockout;
`ifdef OR1200_ALARM_LOCKOUT_EN
        cpu_halt_d  = (state_d == ST_LOCKOUT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            filt_cnt_q  <= 4'd0;
            syndrome_q  <= 6'd0;
            alarm_cnt_q <= 4'd0;
            mask_q      <= 6'b111111;
            alarm_irq_q <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef OR1200_ALARM_LOCKOUT_EN
            cpu_halt_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            filt_cnt_q  <= filt_cnt_d;
            syndrome_q  <= syndrome_d;
            alarm_cnt_q <= alarm_cnt_d;
            mask_q      <= mask_d;
            alarm_irq_q <= alarm_irq_d;
            cfg_err_q   <= cfg_err_d;
`ifdef OR1200_ALARM_LOCKOUT_EN
            cpu_halt_q  <= cpu_halt_d;
`endif
        end
    end

    assign alarm_irq = alarm_irq_q;
    assign syndrome  = syndrome_q;
    assign alarm_cnt = alarm_cnt_q;
    assign cfg_err   = cfg_err_q;
    assign mask      = mask_q;
`ifdef OR1200_ALARM_LOCKOUT_EN
    assign cpu_halt  = cpu_halt_q;
`else
    assign cpu_halt  = 1'b0;
`endif

endmodule

// File: tb/tb_or1200_alarm_ctrl.sv
// Testbench for or1200_alarm_ctrl: directed scenarios plus random traffic, scoreboarded against a behavioural model.
// The driver pushes the expected post-edge outputs into a queue; a monitor pops and compares every cycle.
// Async reset is exercised mid-run and checked directly.

module tb_or1200_alarm_ctrl;

    localparam int FILT = 2;
    localparam int MAXA = 3;
`ifdef OR1200_ALARM_LOCKOUT_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] chk_ok;
    logic       alarm_ack;
    logic       cfg_we;
    logic [5:0] cfg_mask;
    logic       cfg_supv;
    logic       alarm_irq;
    logic [5:0] syndrome;
    logic [3:0] alarm_cnt;
    logic       cpu_halt;
    logic       cfg_err;
    logic [5:0] mask;

    always #5 clk = ~clk;

    or1200_alarm_ctrl #(.FILT_CYC(FILT), .MAX_ALARMS(MAXA)) dut (
        .clk      (clk),
        .rst      (rst),
        .chk_ok   (chk_ok),
        .alarm_ack(alarm_ack),
        .cfg_we   (cfg_we),
        .cfg_mask (cfg_mask),
        .cfg_supv (cfg_supv),
        .alarm_irq(alarm_irq),
        .syndrome (syndrome),
        .alarm_cnt(alarm_cnt),
        .cpu_halt (cpu_halt),
        .cfg_err  (cfg_err),
        .mask     (mask)
    );

    typedef struct packed {
        logic       irq;
        logic [5:0] syn;
        logic [3:0] cnt;
        logic       halt;
        logic       err;
        logic [5:0] msk;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: an alarm flag, a locked flag, the length of the
    // current run of failing cycles, and the accumulated failure set.
    bit         m_alarm;
    bit         m_locked;
    int         m_run;
    logic [5:0] m_synd;
    logic [5:0] m_mask;
    int         m_cnt;
    bit         m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_alarm  = 1'b0;
        m_locked = 1'b0;
        m_run    = 0;
        m_synd   = 6'd0;
        m_mask   = 6'h3f;
        m_cnt    = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_step(input logic [5:0] c, input logic a, input logic w,
                              input logic [5:0] cm, input logic s);
        logic [5:0] f;
        f     = ~c & m_mask;
        m_err = 1'b0;
        if (m_locked) begin
            // nothing moves until reset
        end else if (m_alarm) begin
            if (w) m_err = 1'b1;
            if (a) begin
                if (m_cnt < 15) m_cnt++;
                if (LOCK && m_cnt >= MAXA) begin
                    m_locked = 1'b1;
                    m_synd   = m_synd | f;
                end else begin
                    m_alarm = 1'b0;
                    m_synd  = 6'd0;
                    m_run   = 0;
                end
            end else begin
                m_synd = m_synd | f;
            end
        end else begin
            if (w) begin
                if (s && m_run == 0) m_mask = cm;
                else                 m_err  = 1'b1;
            end
            if (f != 6'd0) begin
                m_run++;
                m_synd = (m_run == 1) ? f : (m_synd | f);
                if (m_run == FILT) m_alarm = 1'b1;
            end else begin
                m_run  = 0;
                m_synd = 6'd0;
            end
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, queue the
    // expected outputs, return at the following falling edge.
    task automatic step(input logic [5:0] c, input logic a = 1'b0, input logic w = 1'b0,
                        input logic [5:0] cm = 6'h3f, input logic s = 1'b0);
        exp_t e;
        chk_ok    = c;
        alarm_ack = a;
        cfg_we    = w;
        cfg_mask  = cm;
        cfg_supv  = s;
        @(posedge clk);
        model_step(c, a, w, cm, s);
        e.irq  = m_alarm | m_locked;
        e.syn  = m_synd;
        e.cnt  = 4'(m_cnt);
        e.halt = m_locked;
        e.err  = m_err;
        e.msk  = m_mask;
        exp_q.push_back(e);
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_irq"},  alarm_irq, 0);
        check({tag, "_syn"},  syndrome,  0);
        check({tag, "_cnt"},  alarm_cnt, 0);
        check({tag, "_halt"}, cpu_halt,  0);
        check({tag, "_err"},  cfg_err,   0);
        check({tag, "_mask"}, mask,      6'h3f);
    endtask

    // Asynchronous reset pulse asserted mid-cycle, away from any clock edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
    endtask

    task automatic alarm_round();
        step(6'h3e);
        step(6'h3e);
        step(6'h3f, 1'b1);
    endtask

    // Monitor: compare whatever the DUT presents after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_irq",  alarm_irq, e.irq);
                check("sb_syn",  syndrome,  e.syn);
                check("sb_cnt",  alarm_cnt, e.cnt);
                check("sb_halt", cpu_halt,  e.halt);
                check("sb_err",  cfg_err,   e.err);
                check("sb_mask", mask,      e.msk);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] c, cm;
        logic       a, w, s;

        rst       = 1'b0;
        chk_ok    = 6'h3f;
        alarm_ack = 1'b0;
        cfg_we    = 1'b0;
        cfg_mask  = 6'h3f;
        cfg_supv  = 1'b0;
        model_reset();
        #7;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        #2;

        // Single-cycle glitch is filtered out.
        step(6'h3e);
        check("glitch_irq0", alarm_irq, 0);
        step(6'h3f);
        check("glitch_irq1", alarm_irq, 0);
        check("glitch_syn", syndrome, 0);

        // Two consecutive failures from different checkers raise the alarm.
        step(6'h3e);
        check("lat_irq_early", alarm_irq, 0);
        step(6'h2f);
        check("lat_irq", alarm_irq, 1);
        check("lat_syn", syndrome, 6'b010001);
        step(6'h3f, 1'b1);
        check("ack_irq", alarm_irq, 0);
        check("ack_cnt", alarm_cnt, 1);
        check("ack_syn", syndrome, 0);

        // Escalation.
        alarm_round();
        alarm_round();
        check("esc_cnt", alarm_cnt, 3);
        if (LOCK) begin
            check("esc_halt", cpu_halt, 1);
            check("esc_irq", alarm_irq, 1);
            step(6'h3f, 1'b1);
            check("esc_ack4_cnt", alarm_cnt, 3);
            check("esc_ack4_halt", cpu_halt, 1);
        end else begin
            check("esc_halt", cpu_halt, 0);
            check("esc_irq", alarm_irq, 0);
        end
        do_reset("rst_mid");

        // Mask writes.
        step(6'h3f, 1'b0, 1'b1, 6'h3e, 1'b0);
        check("usr_we_err", cfg_err, 1);
        check("usr_we_mask", mask, 6'h3f);
        step(6'h3f);
        check("err_pulse_end", cfg_err, 0);
        step(6'h3f, 1'b0, 1'b1, 6'h3e, 1'b1);
        check("supv_we_mask", mask, 6'h3e);
        check("supv_we_err", cfg_err, 0);
        repeat (10) step(6'h3e);
        check("masked_irq", alarm_irq, 0);
        check("masked_syn", syndrome, 0);
        step(6'h3f, 1'b0, 1'b1, 6'h3f, 1'b1);

        // Write attempted while alarmed is rejected.
        step(6'h3e);
        step(6'h3e);
        step(6'h3e, 1'b0, 1'b1, 6'h00, 1'b1);
        check("alarm_we_err", cfg_err, 1);
        check("alarm_we_mask", mask, 6'h3f);
        check("alarm_we_irq", alarm_irq, 1);
        step(6'h3f, 1'b1);

        // Many rounds: count saturates, halt depends on the build.
        repeat (20) alarm_round();
        if (LOCK) begin
            check("sat_halt", cpu_halt, 1);
            check("sat_irq", alarm_irq, 1);
        end else begin
            check("sat_cnt", alarm_cnt, 15);
            check("sat_halt", cpu_halt, 0);
        end
        do_reset("rst_sat");

        // Random traffic with periodic asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            c  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h3f;
            a  = ($urandom_range(0, 3) == 0);
            w  = ($urandom_range(0, 7) == 0);
            cm = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'($urandom);
            s  = 1'($urandom_range(0, 1));
            step(c, a, w, cm, s);
            if (i % 300 == 299) do_reset("rst_rand");
        end

        chk_ok    = 6'h3f;
        alarm_ack = 1'b0;
        cfg_we    = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
